// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : shared constants and helpers for the switch debouncer
// Revision     : 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

  // Depth of the input synchronizer; only the first stage may go metastable.
  localparam int unsigned SYNC_STAGES = 2;

  // Level every debounced output takes on reset.
  localparam logic SW_RESET_LEVEL = 1'b0;

  // Width needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) begin
        result = unsigned'(i + 1);
      end
    end
    return result;
  endfunction

endpackage : debounce_pkg

`default_nettype wire

// File: rtl/debounce_chan.sv
// ============================================================================
// debounce_chan : single-bit synchronizer plus stability counter
// Revision      : 1.0
// ============================================================================
`default_nettype none

module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic pulse,
  output logic idle
);

  localparam int unsigned CNT_W = clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   pulse_q, pulse_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    q_d     = q_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync_out != q_q) begin
      if (cnt_q == CNT_MAX) begin
        q_d     = sync_out;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Idle is judged on next-state values so the registered settled flag lines up with the outputs.
  assign idle = (sync_d[SYNC_STAGES-1] == q_d) && (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      q_q     <= SW_RESET_LEVEL;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      pulse_q <= pulse_d;
    end
  end

  assign q     = q_q;
  assign pulse = pulse_q;

endmodule : debounce_chan

`default_nettype wire

// File: rtl/switch_debounce.sv
// ============================================================================
// switch_debounce : multi-channel switch/pushbutton synchronizer and debouncer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module switch_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] chg,
  output logic             settled
);

  logic [WIDTH-1:0] idle;
  logic             settled_q, settled_d;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      debounce_chan #(
        .STABLE_CYCLES(STABLE_CYCLES)
      ) u_chan (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sw_in[i]),
        .q    (sw_out[i]),
        .pulse(chg[i]),
        .idle (idle[i])
      );
    end
  endgenerate

  always_comb begin
    settled_d = &idle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settled_q <= 1'b1;
    end else begin
      settled_q <= settled_d;
    end
  end

  assign settled = settled_q;

endmodule : switch_debounce

`default_nettype wire

// File: tb/tb_switch_debounce.sv
// ============================================================================
// tb_switch_debounce : bench for switch_debounce (WIDTH=3, STABLE_CYCLES=4)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_switch_debounce;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned STABLE = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] chg;
  logic             settled;

  int vectors = 0;
  int errors  = 0;

  switch_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .chg    (chg),
    .settled(settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sw_in samples since reset; an output flips once the value
  // two samples back (the synchronized level) has differed from it on STABLE
  // consecutive post-reset edges.
  bit [WIDTH-1:0] in_hist[$];
  bit [WIDTH-1:0] s2_hist[$];
  bit [WIDTH-1:0] m_out;
  bit [WIDTH-1:0] m_chg;
  bit             m_settled;

  task automatic model_edge(input bit r, input bit [WIDTH-1:0] sw);
    bit [WIDTH-1:0] s2, old, nxt;
    int n;
    bit all_diff;
    if (!r) begin
      in_hist.delete();
      s2_hist.delete();
      m_out     = '0;
      m_chg     = '0;
      m_settled = 1'b1;
      return;
    end
    n  = in_hist.size();
    s2 = (n >= 2) ? in_hist[n-2] : '0;
    s2_hist.push_back(s2);
    old   = m_out;
    m_chg = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (s2_hist.size() >= STABLE) begin
        all_diff = 1'b1;
        for (int t = 0; t < STABLE; t++) begin
          if (s2_hist[s2_hist.size()-1-t][b] == old[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_out[b] = ~old[b];
          m_chg[b] = 1'b1;
        end
      end
    end
    in_hist.push_back(sw);
    nxt = (in_hist.size() >= 2) ? in_hist[in_hist.size()-2] : '0;
    m_settled = 1'b1;
    for (int b = 0; b < WIDTH; b++) begin
      if (nxt[b] != m_out[b]) m_settled = 1'b0;
      if (!m_chg[b] && (s2[b] != old[b])) m_settled = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got out=%b chg=%b settled=%b, want out=%b chg=%b settled=%b",
               name, act[6:4], act[3:1], act[0], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock edge: drive at negedge, update the model on the edge, compare 1ns later.
  task automatic step(input bit r, input bit [WIDTH-1:0] sw);
    @(negedge clk);
    rst_n = r;
    sw_in = sw;
    @(posedge clk);
    model_edge(r, sw);
    #1;
    check("model", {sw_out, chg, settled}, {m_out, m_chg, m_settled});
  endtask

  typedef struct {
    bit             rst_n;
    bit [WIDTH-1:0] sw;
    bit [WIDTH-1:0] out;
    bit [WIDTH-1:0] chg;
    bit             settled;
  } vec_t;

  vec_t tbl[18];
  bit   bounce_pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    bit [WIDTH-1:0] sw;
    bit [WIDTH-1:0] mask;
    bit             r;
    bit             v;
    int             pulses;
    int             flip_at;

    rst_n = 1'b0;
    sw_in = '0;

    // reset, quiet hold, clean 000->100 step, then a 3-cycle glitch on bit0
    tbl[0]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[1]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[2]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[3]  = '{1'b1, 3'b100, 3'b000, 3'b000, 1'b1};
    tbl[4]  = '{1'b1, 3'b100, 3'b000, 3'b000, 1'b0};
    tbl[5]  = '{1'b1, 3'b100, 3'b000, 3'b000, 1'b0};
    tbl[6]  = '{1'b1, 3'b100, 3'b000, 3'b000, 1'b0};
    tbl[7]  = '{1'b1, 3'b100, 3'b000, 3'b000, 1'b0};
    tbl[8]  = '{1'b1, 3'b100, 3'b100, 3'b100, 1'b1};
    tbl[9]  = '{1'b1, 3'b100, 3'b100, 3'b000, 1'b1};
    tbl[10] = '{1'b1, 3'b100, 3'b100, 3'b000, 1'b1};
    tbl[11] = '{1'b1, 3'b101, 3'b100, 3'b000, 1'b1};
    tbl[12] = '{1'b1, 3'b101, 3'b100, 3'b000, 1'b0};
    tbl[13] = '{1'b1, 3'b101, 3'b100, 3'b000, 1'b0};
    tbl[14] = '{1'b1, 3'b100, 3'b100, 3'b000, 1'b0};
    tbl[15] = '{1'b1, 3'b100, 3'b100, 3'b000, 1'b0};
    tbl[16] = '{1'b1, 3'b100, 3'b100, 3'b000, 1'b1};
    tbl[17] = '{1'b1, 3'b100, 3'b100, 3'b000, 1'b1};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst_n, tbl[i].sw);
      check($sformatf("table[%0d]", i), {sw_out, chg, settled},
            {tbl[i].out, tbl[i].chg, tbl[i].settled});
    end

    // bounce on bit1: only the final run of four ones may flip it
    pulses  = 0;
    flip_at = -1;
    for (int i = 0; i < 17; i++) begin
      v = (i < 9) ? bounce_pat[i] : 1'b1;
      step(1'b1, {1'b1, v, 1'b0});
      if (chg[1]) begin
        pulses++;
        flip_at = i;
      end
    end
    check_int("bounce_pulses", pulses, 1);
    check_int("bounce_flip_edge", flip_at, 5 + STABLE + 1);
    check("bounce_final", {sw_out, chg, settled}, {3'b110, 3'b000, 1'b1});

    // reset, then all three bits rise together, then bits 2 and 0 fall together
    step(1'b0, 3'b000);
    check("reset_clear", {sw_out, chg, settled}, {3'b000, 3'b000, 1'b1});
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b111);
      check($sformatf("rise_all[%0d]", i), {sw_out, chg},
            {(i >= 5) ? 3'b111 : 3'b000, (i == 5) ? 3'b111 : 3'b000, 1'b0} >> 1);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'b010);
      check($sformatf("fall_20[%0d]", i), {sw_out, chg},
            {(i >= 5) ? 3'b010 : 3'b111, (i == 5) ? 3'b101 : 3'b000, 1'b0} >> 1);
    end

    // reset while bit2 is mid-count discards the progress
    for (int i = 0; i < 4; i++) step(1'b1, 3'b110);
    step(1'b0, 3'b110);
    check("reset_midcount", {sw_out, chg, settled}, {3'b000, 3'b000, 1'b1});
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'b110);
      check($sformatf("post_reset[%0d]", i), {sw_out, chg},
            {(i >= 5) ? 3'b110 : 3'b000, (i == 5) ? 3'b110 : 3'b000, 1'b0} >> 1);
    end

    // randomized traffic with occasional resets
    sw = 3'b110;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) != 0);
      mask = '0;
      for (int b = 0; b < WIDTH; b++) mask[b] = ($urandom_range(0, 5) == 0);
      sw = sw ^ mask;
      step(r, sw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_switch_debounce

`default_nettype wire
